// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multi-cycle MIPS control unit with memory wait states,
//                bne/j support, illegal-opcode halt and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 32,
    parameter int EN_JUMP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BrNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int WAIT_W = $clog2(MEM_LAT + 1);
    localparam logic [WAIT_W-1:0] c_LAST_WAIT = WAIT_W'(MEM_LAT - 1);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd15
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_brne;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [CNT_W-1:0]   r_instr_cnt;
    logic               w_wait_state;
    logic               w_last;
    logic               w_unused_funct;

    // funct is decoded by ALU control; R-type legality depends only on op
    assign w_unused_funct = ^funct;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_last       = (r_wait == c_LAST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_wait      <= '0;
            r_brne      <= 1'b0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts at zero whenever a wait state is (re)entered
            r_wait  <= (w_wait_state && !w_last) ? r_wait + WAIT_W'(1) : '0;
            // Branch sense is captured at decode so BrNe stays a Moore output
            if (r_state == S_DECODE) begin
                r_brne <= (op == c_OP_BNE);
            end
            if (r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end
            if ((r_state != S_FETCH) && (w_next == S_FETCH)) begin
                r_instr_cnt <= r_instr_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BrNe        = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = w_last;
                PCWrite = w_last;
                if (w_last) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (op)
                    c_OP_LW, c_OP_SW:   w_next = S_MEMADR;
                    c_OP_RTYPE:         w_next = S_EXEC;
                    c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
                    c_OP_ADDIU:         w_next = S_ADDIEX;
                    c_OP_J:             w_next = (EN_JUMP != 0) ? S_JUMP : S_HALT;
                    default:            w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (op == c_OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (w_last) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (w_last) begin
                    w_next = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                w_next   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BrNe        = r_brne;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                w_next   = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    assign state     = r_state;
    assign halted    = (r_state == S_HALT);
    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Self-checking bench for mc_ctrl_fsm (two parameter sets).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       hl;
        logic       pcw, pcwc, brne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic r;
    } ent_t;

    localparam logic [5:0] c_LW = 6'b100011, c_SW = 6'b101011, c_R = 6'b000000;
    localparam logic [5:0] c_BEQ = 6'b000100, c_BNE = 6'b000101, c_ADDIU = 6'b001001;
    localparam logic [5:0] c_J = 6'b000010, c_BAD = 6'b111111;

    logic clk, rst_n1, rst_n3;
    logic [5:0] op1, op3;
    logic [5:0] funct1 = 6'h20;
    logic [5:0] funct3 = 6'h22;

    logic d1_pcw, d1_pcwc, d1_brne, d1_iord, d1_mrd, d1_mwr, d1_irw, d1_m2r, d1_rdst, d1_rw, d1_srca, d1_hl;
    logic [1:0] d1_srcb, d1_aluop, d1_pcsrc;
    logic [3:0] d1_st;
    logic [31:0] d1_cyc, d1_ins;
    logic d3_pcw, d3_pcwc, d3_brne, d3_iord, d3_mrd, d3_mwr, d3_irw, d3_m2r, d3_rdst, d3_rw, d3_srca, d3_hl;
    logic [1:0] d3_srcb, d3_aluop, d3_pcsrc;
    logic [3:0] d3_st;
    logic [7:0] d3_cyc, d3_ins;

    mc_ctrl_fsm #(.MEM_LAT(1), .CNT_W(32), .EN_JUMP(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .op(op1), .funct(funct1),
        .PCWrite(d1_pcw), .PCWriteCond(d1_pcwc), .BrNe(d1_brne), .IorD(d1_iord),
        .MemRead(d1_mrd), .MemWrite(d1_mwr), .IRWrite(d1_irw), .MemtoReg(d1_m2r),
        .RegDst(d1_rdst), .RegWrite(d1_rw), .ALUSrcA(d1_srca), .ALUSrcB(d1_srcb),
        .ALUOp(d1_aluop), .PCSource(d1_pcsrc), .state(d1_st), .halted(d1_hl),
        .cycle_cnt(d1_cyc), .instr_cnt(d1_ins)
    );

    mc_ctrl_fsm #(.MEM_LAT(3), .CNT_W(8), .EN_JUMP(0)) dut3 (
        .clk(clk), .rst_n(rst_n3), .op(op3), .funct(funct3),
        .PCWrite(d3_pcw), .PCWriteCond(d3_pcwc), .BrNe(d3_brne), .IorD(d3_iord),
        .MemRead(d3_mrd), .MemWrite(d3_mwr), .IRWrite(d3_irw), .MemtoReg(d3_m2r),
        .RegDst(d3_rdst), .RegWrite(d3_rw), .ALUSrcA(d3_srca), .ALUSrcB(d3_srcb),
        .ALUOp(d3_aluop), .PCSource(d3_pcsrc), .state(d3_st), .halted(d3_hl),
        .cycle_cnt(d3_cyc), .instr_cnt(d3_ins)
    );

    exp_t a1, a3;
    assign a1 = {d1_st, d1_hl, d1_pcw, d1_pcwc, d1_brne, d1_iord, d1_mrd, d1_mwr, d1_irw,
                 d1_m2r, d1_rdst, d1_rw, d1_srca, d1_srcb, d1_aluop, d1_pcsrc};
    assign a3 = {d3_st, d3_hl, d3_pcw, d3_pcwc, d3_brne, d3_iord, d3_mrd, d3_mwr, d3_irw,
                 d3_m2r, d3_rdst, d3_rw, d3_srca, d3_srcb, d3_aluop, d3_pcsrc};

    int checks = 0;
    int errors = 0;
    ent_t q1[$];
    ent_t q3[$];
    int m_cyc1, m_ins1, m_cyc3, m_ins3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for one cycle spent in a given spec state
    function automatic exp_t mk(input int st, input bit last, input bit bne);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mrd = 1; e.srcb = 2'b01; e.irw = last; e.pcw = last; end
            1:  e.srcb = 2'b11;
            2:  begin e.srca = 1; e.srcb = 2'b10; end
            3:  begin e.mrd = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.mwr = 1; e.iord = 1; end
            6:  begin e.srca = 1; e.aluop = 2'b10; end
            7:  begin e.rw = 1; e.rdst = 1; end
            8:  begin e.srca = 1; e.aluop = 2'b01; e.pcwc = 1; e.pcsrc = 2'b01; e.brne = bne; end
            9:  begin e.pcw = 1; e.pcsrc = 2'b10; end
            10: begin e.srca = 1; e.srcb = 2'b10; end
            11: e.rw = 1;
            15: e.hl = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q3.size();
    endfunction

    task automatic push(input int d, input exp_t e, input bit r);
        ent_t x;
        x.e = e;
        x.r = r;
        if (d == 1) q1.push_back(x);
        else q3.push_back(x);
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_ent(input string nm, input exp_t e, input exp_t act,
                           input logic [31:0] ecyc, input logic [31:0] eins,
                           input logic [31:0] acyc, input logic [31:0] ains);
        checks += 2;
        if (act !== e) begin
            errors++;
            $display("FAIL %s ctrl: got %h expected %h (state %0d vs %0d) at %0t",
                     nm, act, e, act.st, e.st, $time);
        end
        if (acyc !== ecyc || ains !== eins) begin
            errors++;
            $display("FAIL %s counters: got cyc %0d ins %0d expected cyc %0d ins %0d at %0t",
                     nm, acyc, ains, ecyc, eins, $time);
        end
    endtask

    // Per-cycle compare against the instruction-level model
    initial begin
        ent_t e1, e3;
        forever begin
            @(negedge clk);
            if (!rst_n1) begin
                m_cyc1 = 0; m_ins1 = 0;
            end else if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk_ent("dut1", e1.e, a1, 32'(m_cyc1), 32'(m_ins1), d1_cyc, d1_ins);
                if (e1.e.st != 4'd15) m_cyc1++;
                if (e1.r) m_ins1++;
            end
            if (!rst_n3) begin
                m_cyc3 = 0; m_ins3 = 0;
            end else if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk_ent("dut3", e3.e, a3, 32'(m_cyc3 % 256), 32'(m_ins3 % 256),
                        32'(d3_cyc), 32'(d3_ins));
                if (e3.e.st != 4'd15) m_cyc3++;
                if (e3.r) m_ins3++;
            end
        end
    end

    // Expected cycle sequence for one instruction, starting at its first FETCH
    task automatic push_instr(input int d, input logic [5:0] o, input int lat, input bit enj);
        bit hlt;
        hlt = 0;
        if (d == 1) op1 = o;
        else op3 = o;
        for (int i = 0; i < lat; i++) push(d, mk(0, i == lat - 1, 0), 0);
        push(d, mk(1, 0, 0), 0);
        case (o)
            c_LW: begin
                push(d, mk(2, 0, 0), 0);
                for (int i = 0; i < lat; i++) push(d, mk(3, 0, 0), 0);
                push(d, mk(4, 0, 0), 1);
            end
            c_SW: begin
                push(d, mk(2, 0, 0), 0);
                for (int i = 0; i < lat; i++) push(d, mk(5, 0, 0), i == lat - 1);
            end
            c_R: begin
                push(d, mk(6, 0, 0), 0);
                push(d, mk(7, 0, 0), 1);
            end
            c_BEQ, c_BNE: push(d, mk(8, 0, o == c_BNE), 1);
            c_ADDIU: begin
                push(d, mk(10, 0, 0), 0);
                push(d, mk(11, 0, 0), 1);
            end
            c_J: if (enj) push(d, mk(9, 0, 0), 1); else hlt = 1;
            default: hlt = 1;
        endcase
        if (hlt) for (int i = 0; i < 4; i++) push(d, mk(15, 0, 0), 0);
    endtask

    task automatic wait_drain(input int d);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain dut%0d: %0d entries left, expected 0", d, qsize(d));
            if (d == 1) q1.delete();
            else q3.delete();
        end
        #1;
    endtask

    task automatic run(input int d, input logic [5:0] o, input int lat, input bit enj);
        push_instr(d, o, lat, enj);
        wait_drain(d);
    endtask

    task automatic reset3();
        @(negedge clk);
        #1 rst_n3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n3 = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n1 = 1'b0;
        rst_n3 = 1'b0;
        op1 = 6'b0;
        op3 = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset state", 32'(d1_st), 32'd0);
        lit("reset halted", 32'(d1_hl), 32'd0);
        lit("reset cycle_cnt", d1_cyc, 32'd0);
        lit("reset instr_cnt", d1_ins, 32'd0);
        lit("reset fetch L1 word", 32'(a1), 32'(mk(0, 1, 0)));
        lit("reset fetch L3 IRWrite", 32'(d3_irw), 32'd0);
        lit("reset fetch L3 MemRead", 32'(d3_mrd), 32'd1);

        rst_n1 = 1'b1;
        run(1, c_ADDIU, 1, 1);
        run(1, c_ADDIU, 1, 1);
        run(1, c_ADDIU, 1, 1);
        run(1, c_R, 1, 1);
        run(1, c_BEQ, 1, 1);
        run(1, c_R, 1, 1);
        lit("prog instr_cnt", d1_ins, 32'd6);
        lit("prog cycle_cnt", d1_cyc, 32'd23);
        run(1, c_LW, 1, 1);
        run(1, c_SW, 1, 1);
        run(1, c_BNE, 1, 1);
        run(1, c_J, 1, 1);
        lit("mix instr_cnt", d1_ins, 32'd10);
        lit("mix cycle_cnt", d1_cyc, 32'd38);
        run(1, c_BAD, 1, 1);
        lit("illegal state", 32'(d1_st), 32'd15);
        lit("illegal halted", 32'(d1_hl), 32'd1);
        lit("illegal cycle_cnt", d1_cyc, 32'd40);
        repeat (5) @(posedge clk);
        #1;
        lit("halt cycle_cnt frozen", d1_cyc, 32'd40);
        lit("halt instr_cnt", d1_ins, 32'd10);
        lit("halt strobes", 32'(a1), 32'(mk(15, 0, 0)));
        rst_n1 = 1'b0;

        rst_n3 = 1'b1;
        run(3, c_LW, 3, 0);
        lit("lw L3 cycles", 32'(d3_cyc), 32'd9);
        lit("lw L3 instr", 32'(d3_ins), 32'd1);
        run(3, c_J, 3, 0);
        lit("j disabled halts", 32'(d3_st), 32'd15);

        reset3();
        run(3, c_SW, 3, 0);
        run(3, c_BNE, 3, 0);
        for (int i = 0; i < 45; i++) run(3, c_R, 3, 0);
        lit("cycle_cnt wrap", 32'(d3_cyc), 32'd27);
        lit("instr after wrap", 32'(d3_ins), 32'd47);

        reset3();
        op3 = c_LW;
        for (int i = 0; i < 3; i++) push(3, mk(0, i == 2, 0), 0);
        push(3, mk(1, 0, 0), 0);
        push(3, mk(2, 0, 0), 0);
        push(3, mk(3, 0, 0), 0);
        push(3, mk(3, 0, 0), 0);
        n = 0;
        while (q3.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        lit("mid-memrd drain", 32'(q3.size()), 32'd0);
        lit("pre-reset in MEMRD", 32'(d3_st), 32'd3);
        rst_n3 = 1'b0;
        #1;
        lit("async reset state", 32'(d3_st), 32'd0);
        lit("async reset cycle_cnt", 32'(d3_cyc), 32'd0);
        lit("async reset instr_cnt", 32'(d3_ins), 32'd0);
        lit("async reset word", 32'(a3), 32'(mk(0, 0, 0)));

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
